// File: rtl/frame_pixel_unpacker.sv
// rtl/frame_pixel_unpacker.sv - HPS 256-bit word stream to 8-bit pixel stream unpacker
// Word FIFO, byte serializer and per-frame pixel counter with HPS status return word.

module frame_pixel_unpacker_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 256
) (
  input  logic                      i_clk,
  input  logic                      i_resetn,
  input  logic                      i_flush,
  input  logic                      i_wr,
  input  logic [WIDTH-1:0]          i_wdata,
  input  logic                      i_rd,
  output logic [WIDTH-1:0]          o_rdata,
  output logic                      o_full,
  output logic                      o_empty,
  output logic [$clog2(DEPTH):0]    o_level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   LVL_ONE  = 1;
  localparam logic [AW:0]   LVL_FULL = DEPTH[AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;

  always_ff @(posedge i_clk) begin
    if (i_wr) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_resetn || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (i_wr) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (i_rd) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({i_wr, i_rd})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_full  = (r_level == LVL_FULL);
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
endmodule

module frame_pixel_unpacker #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 19
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [255:0]     data_data,
  input  logic             datavalid_datavalid,
  input  logic [31:0]      data_trigger_export,
  input  logic [CNT_W-1:0] cfg_len,
  output logic [7:0]       pix_data,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic             pix_sof,
  output logic             pix_eof,
  output logic [CNT_W-1:0] cpt_cpt,
  output logic [31:0]      ret_export
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_trig0_q;
  logic [CNT_W-1:0] r_len;
  logic [CNT_W-1:0] r_cpt;
  logic             r_done;
  logic             r_ovf;
  logic [255:0]     r_sh_data;
  logic [4:0]       r_sh_idx;
  logic             r_pix_valid;

  logic             w_run;
  logic             w_abort;
  logic             w_start_edge;
  logic             w_start_go;
  logic             w_xfer;
  logic             w_last_byte;
  logic             w_eof_hit;
  logic             w_eof_xfer;
  logic             w_flush;
  logic             w_sh_free;
  logic             w_fifo_rd;
  logic             w_fifo_wr;
  logic             w_ovf_hit;
  logic [255:0]     w_fifo_head;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [AW:0]      w_fifo_level;
  logic [7:0]       w_level8;
  logic             w_unused_trig;

  assign w_run        = (r_state == S_RUN);
  assign w_abort      = data_trigger_export[1];
  assign w_start_edge = data_trigger_export[0] & ~r_trig0_q;
  assign w_start_go   = w_start_edge & ~w_abort & ~w_run & (cfg_len != '0);
  assign w_xfer       = r_pix_valid & pix_ready;
  assign w_last_byte  = (r_sh_idx == 5'd31);
  assign w_eof_hit    = (r_cpt == r_len - CNT_ONE);
  assign w_eof_xfer   = w_run & w_xfer & w_eof_hit & ~w_abort;

  // Anything that ends or restarts a frame empties both FIFO and serializer.
  assign w_flush   = w_abort | w_start_go | w_eof_xfer;
  assign w_sh_free = ~r_pix_valid | (w_xfer & w_last_byte);
  assign w_fifo_rd = w_run & ~w_flush & w_sh_free & ~w_fifo_empty;
  assign w_fifo_wr = w_run & ~w_flush & datavalid_datavalid & (~w_fifo_full | w_fifo_rd);
  assign w_ovf_hit = w_run & ~w_flush & datavalid_datavalid & w_fifo_full & ~w_fifo_rd;

  assign w_unused_trig = ^data_trigger_export[31:2];

  frame_pixel_unpacker_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (256)
  ) u_fifo (
    .i_clk    (clk_clk),
    .i_resetn (reset_reset_n),
    .i_flush  (w_flush),
    .i_wr     (w_fifo_wr),
    .i_wdata  (data_data),
    .i_rd     (w_fifo_rd),
    .o_rdata  (w_fifo_head),
    .o_full   (w_fifo_full),
    .o_empty  (w_fifo_empty),
    .o_level  (w_fifo_level)
  );

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: if (w_start_go) w_state_nxt = S_RUN;
        S_RUN:          if (w_eof_xfer) w_state_nxt = S_DONE;
        default:        w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      r_trig0_q <= 1'b0;
      r_len     <= '0;
      r_cpt     <= '0;
      r_done    <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_trig0_q <= data_trigger_export[0];
      if (w_start_go) begin
        r_len  <= cfg_len;
        r_cpt  <= '0;
        r_done <= 1'b0;
        r_ovf  <= 1'b0;
      end else begin
        if (w_abort) begin
          r_done <= 1'b0;
        end else if (w_eof_xfer) begin
          r_done <= 1'b1;
        end
        // Abort freezes the count even if a handshake coincides with it.
        if (w_run && w_xfer && !w_abort) begin
          r_cpt <= r_cpt + CNT_ONE;
        end
        if (w_ovf_hit) begin
          r_ovf <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      r_sh_data   <= '0;
      r_sh_idx    <= '0;
      r_pix_valid <= 1'b0;
    end else if (w_flush) begin
      r_sh_idx    <= '0;
      r_pix_valid <= 1'b0;
    end else if (w_fifo_rd) begin
      r_sh_data   <= w_fifo_head;
      r_sh_idx    <= '0;
      r_pix_valid <= 1'b1;
    end else if (w_xfer) begin
      if (w_last_byte) begin
        r_pix_valid <= 1'b0;
      end else begin
        r_sh_data <= {8'h00, r_sh_data[255:8]};
        r_sh_idx  <= r_sh_idx + 5'd1;
      end
    end
  end

  assign w_level8   = 8'(w_fifo_level);
  assign pix_data   = r_sh_data[7:0];
  assign pix_valid  = r_pix_valid;
  assign pix_sof    = r_pix_valid & (r_cpt == '0);
  assign pix_eof    = r_pix_valid & w_eof_hit;
  assign cpt_cpt    = r_cpt;
  assign ret_export = {16'h0000, w_level8, 5'b00000, r_ovf, r_done, w_run};
endmodule

// File: tb/tb_frame_pixel_unpacker.sv
// tb/tb_frame_pixel_unpacker.sv - directed table-driven bench for frame_pixel_unpacker
module tb_frame_pixel_unpacker;
  localparam int CNT_W = 19;

  logic             clk = 1'b0;
  logic             rstn;
  logic [255:0]     data;
  logic             dv;
  logic [31:0]      trig;
  logic [CNT_W-1:0] cfg_len;
  logic [7:0]       pix_data;
  logic             pix_valid;
  logic             pix_ready;
  logic             pix_sof;
  logic             pix_eof;
  logic [CNT_W-1:0] cpt_cpt;
  logic [31:0]      ret_export;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int         len;
    int         nwords;
    logic [7:0] seed;
    logic [3:0] rpat;
    logic [7:0] exp_last;
    logic [31:0] exp_ret;
  } frame_vec_t;

  frame_vec_t vecs[5];

  always #5 clk = ~clk;

  frame_pixel_unpacker #(
    .FIFO_DEPTH (4),
    .CNT_W      (CNT_W)
  ) dut (
    .clk_clk             (clk),
    .reset_reset_n       (rstn),
    .data_data           (data),
    .datavalid_datavalid (dv),
    .data_trigger_export (trig),
    .cfg_len             (cfg_len),
    .pix_data            (pix_data),
    .pix_valid           (pix_valid),
    .pix_ready           (pix_ready),
    .pix_sof             (pix_sof),
    .pix_eof             (pix_eof),
    .cpt_cpt             (cpt_cpt),
    .ret_export          (ret_export)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [255:0] mkword(input logic [7:0] seed, input int w);
    logic [255:0] v;
    for (int i = 0; i < 32; i++) v[i*8 +: 8] = seed + 8'(w * 32 + i);
    return v;
  endfunction

  task automatic start_frame(input int len);
    trig = 32'h0;
    tick();
    cfg_len = CNT_W'(len);
    trig = 32'h1;
    tick();
    trig = 32'h0;
  endtask

  task automatic run_frame(input frame_vec_t v, input int idx);
    int got;
    int first_v;
    logic prev_stall;
    logic [7:0] prev_d;
    logic quiet;
    string nm;
    nm = $sformatf("frame%0d", idx);
    got = 0;
    first_v = -1;
    prev_stall = 1'b0;
    prev_d = 8'h00;
    start_frame(v.len);
    chk({nm, "_start_cpt"}, 32'(cpt_cpt), 32'h0);
    chk({nm, "_start_ret"}, ret_export, 32'h1);
    for (int cyc = 0; cyc < v.nwords + 4 * v.len + 40 && got < v.len; cyc++) begin
      if (prev_stall) chk({nm, "_stall_hold"}, {23'h0, pix_valid, pix_data}, {23'h0, 1'b1, prev_d});
      if (pix_valid && first_v < 0) first_v = cyc;
      pix_ready = v.rpat[cyc % 4];
      dv = (cyc < v.nwords);
      data = mkword(v.seed, cyc);
      if (pix_valid && pix_ready) begin
        chk({nm, "_pixel"}, {3'h0, pix_sof, pix_eof, cpt_cpt, pix_data},
            {3'h0, got == 0, got == v.len - 1, CNT_W'(got), v.seed + 8'(got)});
        if (got == v.len - 1) chk({nm, "_last_value"}, 32'(pix_data), 32'(v.exp_last));
        got++;
      end
      prev_stall = pix_valid && !pix_ready;
      prev_d = pix_data;
      tick();
    end
    dv = 1'b0;
    pix_ready = 1'b1;
    chk({nm, "_count"}, got, v.len);
    chk({nm, "_first_latency"}, first_v, 2);
    chk({nm, "_end_valid_cpt"}, {12'h0, pix_valid, cpt_cpt}, {12'h0, 1'b0, CNT_W'(v.len)});
    chk({nm, "_end_ret"}, ret_export, v.exp_ret);
    quiet = 1'b1;
    repeat (4) begin
      if (pix_valid) quiet = 1'b0;
      tick();
    end
    chk({nm, "_quiet_after"}, 32'(quiet), 32'h1);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int got;
    logic hit;
    logic quiet;

    vecs[0] = '{64,  2, 8'h00, 4'hF, 8'h3F, 32'h2};
    vecs[1] = '{40,  2, 8'h80, 4'hF, 8'hA7, 32'h2};
    vecs[2] = '{64,  2, 8'h40, 4'h5, 8'h7F, 32'h2};
    vecs[3] = '{100, 4, 8'h11, 4'hB, 8'h74, 32'h2};
    vecs[4] = '{1,   1, 8'hA5, 4'hF, 8'hA5, 32'h2};

    rstn = 1'b0;
    data = '0;
    dv = 1'b0;
    trig = 32'h0;
    cfg_len = '0;
    pix_ready = 1'b0;
    @(negedge clk);
    tick();
    tick();
    chk("reset_outputs", {20'h0, pix_valid, pix_sof, pix_eof, pix_data}, 32'h0);
    chk("reset_cpt", 32'(cpt_cpt), 32'h0);
    chk("reset_ret", ret_export, 32'h0);
    rstn = 1'b1;
    tick();

    // Words in IDLE are discarded; a zero-length start is ignored.
    quiet = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      dv = (cyc < 3);
      data = mkword(8'h55, cyc);
      if (pix_valid) quiet = 1'b0;
      tick();
    end
    dv = 1'b0;
    chk("idle_quiet", 32'(quiet), 32'h1);
    chk("idle_ret", ret_export, 32'h0);
    start_frame(0);
    chk("zero_len_ret", ret_export, 32'h0);
    for (int cyc = 0; cyc < 6; cyc++) begin
      dv = (cyc < 2);
      data = mkword(8'h66, cyc);
      if (pix_valid || ret_export != 32'h0) quiet = 1'b0;
      tick();
    end
    dv = 1'b0;
    chk("zero_len_quiet", 32'(quiet), 32'h1);

    for (int i = 0; i < 5; i++) run_frame(vecs[i], i);

    // Overflow: six words with the sink stalled, sixth is dropped.
    start_frame(256);
    pix_ready = 1'b0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      if (cyc == 5) chk("ovf_before_drop", ret_export, 32'h0401);
      dv = 1'b1;
      data = mkword(8'h07, cyc);
      tick();
    end
    dv = 1'b0;
    chk("ovf_set", ret_export, 32'h0405);
    got = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      pix_ready = 1'b1;
      if (pix_valid) begin
        chk("ovf_pixel", 32'(pix_data), 32'(8'h07 + 8'(got)));
        got++;
      end
      tick();
    end
    chk("ovf_accepted_count", got, 160);
    trig = 32'h2;
    tick();
    chk("ovf_abort_ret", ret_export, 32'h4);
    chk("ovf_abort_cpt", 32'(cpt_cpt), 32'd160);
    trig = 32'h0;

    // Abort at pixel 10, start blocked while abort held, then clean rerun.
    start_frame(64);
    hit = 1'b0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (cpt_cpt == 10) begin
        hit = 1'b1;
        trig = 32'h2;
        pix_ready = 1'b0;
        dv = 1'b0;
        break;
      end
      pix_ready = 1'b1;
      dv = (cyc < 2);
      data = mkword(8'h00, cyc);
      tick();
    end
    chk("abort_reached_10", 32'(hit), 32'h1);
    tick();
    chk("abort_valid_cpt", {12'h0, pix_valid, cpt_cpt}, {12'h0, 1'b0, 19'd10});
    chk("abort_ret", ret_export, 32'h0);
    trig = 32'h3;
    cfg_len = 19'd32;
    tick();
    chk("abort_blocks_start", ret_export, 32'h0);
    trig = 32'h0;
    run_frame('{32, 1, 8'h33, 4'hF, 8'h52, 32'h2}, 5);

    // Reset in the middle of a frame.
    start_frame(64);
    hit = 1'b0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (cpt_cpt == 5) begin
        hit = 1'b1;
        break;
      end
      pix_ready = 1'b1;
      dv = (cyc < 2);
      data = mkword(8'h20, cyc);
      tick();
    end
    chk("rst_mid_reached_5", 32'(hit), 32'h1);
    rstn = 1'b0;
    dv = 1'b0;
    tick();
    chk("rst_mid_outputs", {20'h0, pix_valid, pix_sof, pix_eof, pix_data}, 32'h0);
    chk("rst_mid_cpt", 32'(cpt_cpt), 32'h0);
    chk("rst_mid_ret", ret_export, 32'h0);
    rstn = 1'b1;
    quiet = 1'b1;
    repeat (6) begin
      if (pix_valid) quiet = 1'b0;
      tick();
    end
    chk("rst_mid_quiet", 32'(quiet), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/frame_pixel_unpacker.md
Name: frame_pixel_unpacker

Overview:
- Fabric-side consumer of the HPS-to-FPGA 256-bit word stream (data word + datavalid strobe + trigger register).
- Buffers incoming words in a small FIFO and serializes each word into 8-bit pixels on a valid/ready stream toward the image pipeline.
- Counts emitted pixels per frame and returns a status word for the HPS return register.

Parameters:
- FIFO_DEPTH, 4, number of 256-bit words buffered; power of two, at least 2.
- CNT_W, 19, width of the frame length and pixel counter.

Ports:
- clk_clk  in  1  single system clock.
- reset_reset_n  in  1  synchronous, active-low reset.
- data_data  in  256  word from the HPS; byte 0 = bits 7:0.
- datavalid_datavalid  in  1  one-cycle strobe qualifying data_data.
- data_trigger_export  in  32  bit0 = start (rising edge); bit1 = abort (level); other bits ignored.
- cfg_len  in  CNT_W  frame length in pixels; sampled on the start edge.
- pix_data  out  8  pixel byte.
- pix_valid  out  1  pix_data valid.
- pix_ready  in  1  downstream accept.
- pix_sof  out  1  high with the first pixel of the frame.
- pix_eof  out  1  high with the last pixel of the frame.
- cpt_cpt  out  CNT_W  pixels transferred in the current frame.
- ret_export  out  32  status word:
  - bit0 busy
  - bit1 done
  - bit2 overflow
  - bits 15:8 FIFO level, zero-extended
  - all other bits 0

Behaviour:
- Reset (reset_reset_n=0 at a clock edge):
  - State goes to IDLE; FIFO and shift register are emptied.
  - All outputs are 0: pix_valid/sof/eof=0, cpt_cpt=0, ret_export=0, pix_data=0.
  - The registered previous value of trigger bit0 is cleared.
- Start edge: trigger bit0 registered each cycle; start_edge = bit0 & ~bit0_q.
- States IDLE, RUN, DONE.
- IDLE or DONE:
  - Words on datavalid are discarded.
  - On start_edge with cfg_len != 0 and abort=0:
    - latch cfg_len;
    - cpt_cpt := 0, done := 0, overflow := 0;
    - FIFO and shift register are flushed;
    - next state is RUN.
  - A start_edge with cfg_len == 0 is ignored.
- RUN:
  - busy=1.
  - datavalid writes data_data into the FIFO.
  - If the FIFO is full and no read occurs in the same cycle, the word is dropped and overflow is set (sticky until the next start).
  - A simultaneous write and read on a full FIFO is legal and is not an overflow.
- Serializer:
  - When the shift register is empty, or its last byte transfers this cycle, and the FIFO is non-empty, the head word is loaded.
  - Bytes are emitted 0..31 in order.
  - A transfer occurs when pix_valid & pix_ready.
  - pix_data and pix_valid are held stable while pix_valid=1 & pix_ready=0.
- Latency and throughput:
  - A word strobed in cycle N (FIFO empty, serializer idle) shows byte 0 with pix_valid=1 in cycle N+2.
  - Back-to-back words under continuous pix_ready give 1 pixel/cycle with no gap between words.
- Counter:
  - cpt_cpt increments by 1 per transfer.
  - pix_sof=1 while cpt_cpt==0 and pix_valid.
  - pix_eof=1 while cpt_cpt==len-1 and pix_valid.
- End of frame:
  - On the eof transfer: cpt_cpt becomes len, state goes to DONE, done=1, busy=0.
  - Remaining bytes in the current word and all FIFO contents are flushed; pix_valid=0 next cycle.
- Short frames: len not a multiple of 32 ends mid-word; the remainder is discarded.
- Counter width: with CNT_W=19, len up to 524287; the counter never wraps because the frame ends at len.
- Abort (bit1=1, any state, evaluated at each edge):
  - Next state is IDLE; FIFO and shift register are flushed; pix_valid=0.
  - busy=0 and done=0; overflow and cpt_cpt are held.
  - start_edge is ignored while abort=1.
- start_edge in RUN: ignored.
- Reset mid-frame: identical to power-on reset; no partial pixel is emitted afterward.
- FIFO level in ret_export is the registered occupancy, 0..FIFO_DEPTH.

Test Plan:
- Reset, then start with cfg_len=64, two words with byte i = i (word1 bytes 0x20..0x3F), pix_ready=1 -> 64 transfers with values 0x00..0x3F:
  - sof on 0x00 and eof on 0x3F;
  - first pix_valid two cycles after the first datavalid;
  - cpt_cpt=64 and ret_export=0x00000002 afterward.
- cfg_len=40, two words -> 40 pixels, eof on byte 7 of word 1; bytes 8..31 never appear; FIFO level=0 in DONE.
- pix_ready=0, six back-to-back words (DEPTH=4) -> overflow=1 (bit2) after the write that finds the FIFO full with no read; the output sequence still equals the first accepted words.
- pix_ready toggling 1010 -> pix_data stable during stalls; cpt_cpt equals the number of handshakes exactly.
- Abort asserted at cpt_cpt=10 of 64 -> pix_valid=0 next cycle, busy=0, done=0, cpt_cpt holds 10; a new start with cfg_len=32 clears cpt_cpt and reruns cleanly.
- Words strobed in IDLE, and a start with cfg_len=0 -> no pixels, state stays IDLE, ret_export=0.
